// File: rtl/digit_scanner.sv
// 8-digit multiplexed 7-segment scanner with an all-off gap at the start of every digit slot.
// Optional leading-zero blanking when DIGIT_SCANNER_LEADING_ZERO_BLANK_EN is defined.
module digit_scanner #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 32
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    output logic [7:0]  anodes,
    output logic [7:0]  segments,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SHOW_AT = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] SEG_AT  = CNT_W'(1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [31:0]      shadow_value, shadow_value_next;
    logic [7:0]       shadow_dp, shadow_dp_next;
    logic [7:0]       shadow_en, shadow_en_next;
    logic [7:0]       anodes_next, segments_next;
    logic             frame_start_next;
    logic             slot_wrap;
    logic [6:0]       seg_raw;
    logic [7:0]       blank_mask;

    // Active-low {g,f,e,d,c,b,a}; the dp bit is merged separately.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

`ifdef DIGIT_SCANNER_LEADING_ZERO_BLANK_EN
    // Digit i is blanked when it and every higher shadow nibble are zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = 7; i >= 1; i--) begin
            zero_run      = zero_run & (shadow_value[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run;
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        slot_wrap         = (cnt == CNT_MAX);
        cnt_next          = slot_wrap ? '0 : cnt + 1'b1;
        idx_next          = slot_wrap ? idx + 3'd1 : idx;
        state_next        = state;
        anodes_next       = anodes;
        segments_next     = segments;
        frame_start_next  = 1'b0;
        shadow_value_next = shadow_value;
        shadow_dp_next    = shadow_dp;
        shadow_en_next    = shadow_en;
        seg_raw           = decode(shadow_value[{idx, 2'b00} +: 4]);

        unique case (state)
            BLANK: begin
                if (cnt_next == SHOW_AT) begin
                    state_next = SHOW;
                    if (shadow_en[idx] && !blank_mask[idx])
                        anodes_next = ~(8'b1 << idx);
                end
            end
            SHOW: begin
                if (slot_wrap)
                    state_next = BLANK;
            end
        endcase

        // Inputs are frozen once per frame so a frame never mixes old and new digits.
        if (slot_wrap) begin
            anodes_next = 8'hFF;
            if (idx_next == 3'd0) begin
                shadow_value_next = value;
                shadow_dp_next    = dp;
                shadow_en_next    = digit_en;
                frame_start_next  = 1'b1;
            end
        end

        if (cnt_next == SEG_AT)
            segments_next = blank_mask[idx] ? 8'hFF : {~shadow_dp[idx], seg_raw};
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state        <= BLANK;
            cnt          <= CNT_MAX;
            idx          <= 3'd7;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            anodes       <= 8'hFF;
            segments     <= 8'hFF;
            frame_start  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            shadow_value <= shadow_value_next;
            shadow_dp    <= shadow_dp_next;
            shadow_en    <= shadow_en_next;
            anodes       <= anodes_next;
            segments     <= segments_next;
            frame_start  <= frame_start_next;
        end
    end

endmodule

// File: doc/digit_scanner.md
Name: digit_scanner

Overview:
- Time-multiplexes an 8-digit, 7-segment display.
- Captures a 32-bit hex value once per frame and decodes one nibble per digit slot.
- Drives an active-low one-hot anode vector into the anode shift-register serializer, plus active-low segment lines.
- Inserts an all-off blank gap before every digit so the downstream serializer always finishes a shift/latch sequence before the next anode change.

Parameters:
- CLK_DIV, 100000, sysclk cycles per digit slot. Must be ≥ BLANK_CYCLES+20.
- BLANK_CYCLES, 32, cycles at the start of each slot with all anodes off. Must be ≥ 20, because the downstream serializer needs 18 stable cycles.

Ports:
- sysclk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- value  in  32  hex digits; nibble i (value[4i+3:4i]) shows on digit i
- dp  in  8  decimal point request per digit, 1 = lit
- digit_en  in  8  per-digit enable, 0 = digit never driven
- anodes  out  8  active-low one-hot digit select; 8'hFF = all off
- segments  out  8  active-low {dp,g,f,e,d,c,b,a}
- frame_start  out  1  one-cycle pulse when a new frame begins (digit 0)

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: anodes=8'hFF, segments=8'hFF, frame_start=0.
  - Shadow value/dp/en registers cleared to 0.
  - Counters: idx=7, cnt=CLK_DIV-1, so the first edge after release starts frame 0.
  - Reset asserted mid-slot forces outputs to their reset values immediately, with no clock required.
- Counters:
  - cnt counts 0..CLK_DIV-1 and wraps.
  - On wrap, idx increments mod 8 (7→0).
- All outputs are registered. On the edge entering cnt=0 of slot idx:
  - anodes<=8'hFF.
  - If the new idx=0: shadow_value<=value, shadow_dp<=dp, shadow_en<=digit_en, and frame_start<=1. Otherwise frame_start<=0.
- Edge entering cnt=1: segments<=decode(shadow_value nibble idx), with bit7 cleared when shadow_dp[idx]=1.
- Edge entering cnt=BLANK_CYCLES: anodes<=~(8'b1<<idx) if shadow_en[idx]=1 and the digit is not blanked; otherwise anodes stay 8'hFF.
- Anode state sequence per slot:
  - BLANK: cnt < BLANK_CYCLES, anodes=FF.
  - SHOW: cnt ≥ BLANK_CYCLES.
  - SHOW→BLANK at the slot wrap.
- Anode timing guarantees:
  - At most one anode is low at any time.
  - Every anode change passes through 8'hFF.
  - Anodes change at most twice per slot and are never stable for fewer than 20 cycles.
- Segments are stable ≥ BLANK_CYCLES-1 cycles before the anode goes low and stay constant for the rest of the slot.
- Decode, hex→{dp=1,g..a}:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- Input changes mid-frame have no visible effect until the next frame_start. There is no tearing within a frame.
- A disabled digit still consumes its full slot time, so frame period = 8*CLK_DIV cycles regardless of enables.
- frame_start period = 8*CLK_DIV cycles. The first pulse occurs on the first edge after reset release.

Optional Feature:
- Macro: DIGIT_SCANNER_LEADING_ZERO_BLANK_EN.
- Defined: digit i (7..1) is blanked when shadow nibbles i..7 are all zero. A blanked digit keeps anodes=FF and segments=FF for the whole slot, and its dp is suppressed. Digit 0 is never blanked, so a zero value shows "0". Blanking is evaluated on the shadow registers.
- Undefined: no blanking; zero nibbles display as C0.

Test Plan:
- Reset: assert reset at cnt=BLANK_CYCLES+5 of digit 3 → same-cycle anodes=FF, segments=FF, frame_start=0. After release, frame_start pulses on the first edge and digit 0 anode goes low at cnt=BLANK_CYCLES.
- Scan and decode: CLK_DIV=64, BLANK_CYCLES=24, value=32'h01234567, dp=0, digit_en=FF →
  - digit0: segments=F8, anodes=FE for 40 cycles.
  - digit7: segments=C0, anodes=7F.
  - Each slot has 24 cycles of FF.
  - frame_start every 512 cycles.
- Frame capture: change value to 32'hFFFFFFFF during digit 4 → digits 5-7 still show old nibbles; from the next frame_start all digits show 8E.
- dp and enable: dp=8'h10, digit_en=8'hF0, value=32'h88888888 → anodes stay FF in slots 0-3; slot 4 segments=8'h00; slots 5-7 segments=80.
- Leading zeros: value=32'h000000A0 → with the macro, slots 7-2 anodes=FF, digit1 segments=88, digit0 segments=C0. Without the macro, digits 7-2 show C0.
- Timing checker (all tests): never two anodes low at once, every anode change passes through FF, and no anode pattern is held for fewer than 20 cycles.
